// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic-light conflict monitor.
// Lamp codes, fault causes, monitor states and the transition legality rule.
package tlc_pkg;

  typedef enum logic [1:0] {
    GREEN   = 2'b00,
    YELLOW  = 2'b01,
    RED     = 2'b10,
    INVALID = 2'b11
  } lamp_t;

  // Numeric value doubles as priority: lower non-zero code wins.
  typedef enum logic [2:0] {
    FC_NONE      = 3'd0,
    FC_INVALID   = 3'd1,
    FC_CONFLICT  = 3'd2,
    FC_ILLEGAL   = 3'd3,
    FC_SHORT_YEL = 3'd4,
    FC_LONG_YEL  = 3'd5
  } fault_code_t;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } mon_state_t;

  localparam int MIN_YELLOW_DEF = 20;
  localparam int MAX_YELLOW_DEF = 40;

  function automatic logic is_legal_trans(lamp_t prev, lamp_t cur);
    return (cur == prev) ||
           (prev == GREEN  && cur == YELLOW) ||
           (prev == YELLOW && cur == RED)    ||
           (prev == RED    && cur == GREEN);
  endfunction

endpackage

// File: rtl/tlc_approach_checker.sv
// Per-approach lamp checker: yellow dwell counter plus invalid, transition
// and yellow-duration flags. All flags are forced low unless run_en_i is set.
module tlc_approach_checker
  import tlc_pkg::*;
#(
  parameter int MIN_YELLOW = MIN_YELLOW_DEF,
  parameter int MAX_YELLOW = MAX_YELLOW_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] cur_i,
  input  logic [1:0] prev_i,
  input  logic       run_en_i,
  output logic       invalid_o,
  output logic       illegal_trans_o,
  output logic       short_yel_o,
  output logic       long_yel_o,
  output logic       yel_to_red_o
);

  localparam logic [5:0] MinYel = 6'(MIN_YELLOW);
  localparam logic [5:0] MaxYel = 6'(MAX_YELLOW);

  lamp_t      cur;
  lamp_t      prev;
  logic [5:0] yel_cnt_q;
  logic [5:0] yel_cnt_d;

  assign cur  = lamp_t'(cur_i);
  assign prev = lamp_t'(prev_i);

  // The counter only runs while monitoring, so ARM and FAULT leave it at zero
  // and the first RUN yellow sample always counts as 1.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the signal unassigned (avoids a latch).
    yel_cnt_d = '0;
    if (run_en_i && cur == YELLOW) begin
      yel_cnt_d = (yel_cnt_q == 6'd63) ? yel_cnt_q : yel_cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yel_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      yel_cnt_q <= yel_cnt_d;
    end
  end

  assign yel_to_red_o    = run_en_i && prev == YELLOW && cur == RED;
  assign invalid_o       = run_en_i && cur == INVALID;
  assign illegal_trans_o = run_en_i && !is_legal_trans(prev, cur);
  assign short_yel_o     = yel_to_red_o && (yel_cnt_q < MinYel);
  // Fires on the sample that would push the dwell to MAX_YELLOW+1.
  assign long_yel_o      = run_en_i && cur == YELLOW && (yel_cnt_q == MaxYel);

endmodule

// File: rtl/light_conflict_monitor.sv
// Safety monitor for a highway/farm intersection: checks lamp sequencing,
// latches the first fault, requests flashing red and counts highway cycles.
module light_conflict_monitor
  import tlc_pkg::*;
#(
  parameter int MIN_YELLOW = MIN_YELLOW_DEF,
  parameter int MAX_YELLOW = MAX_YELLOW_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  highway_light,
  input  logic [1:0]  farm_light,
  input  logic        fault_clr,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic        flash_red,
  output logic [15:0] cycle_cnt
);

  mon_state_t  state_q;
  lamp_t       hw_prev_q;
  lamp_t       fm_prev_q;
  logic        fault_q;
  fault_code_t fault_code_q;
  logic        flash_red_q;
  logic [15:0] cycle_cnt_q;

  lamp_t       hw_cur;
  lamp_t       fm_cur;
  logic        run_en;
  logic        conflict;
  logic        both_red;
  fault_code_t det_code;

  logic hw_invalid, hw_illegal, hw_short, hw_long, hw_yel_to_red;
  logic fm_invalid, fm_illegal, fm_short, fm_long, fm_yel_to_red;

  assign hw_cur   = lamp_t'(highway_light);
  assign fm_cur   = lamp_t'(farm_light);
  assign run_en   = (state_q == ST_RUN);
  assign conflict = (hw_cur != RED) && (fm_cur != RED);
  assign both_red = (hw_cur == RED) && (fm_cur == RED);

  tlc_approach_checker #(.MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW)) u_highway (
    .clk             (clk),
    .rst_n           (rst_n),
    .cur_i           (highway_light),
    .prev_i          (hw_prev_q),
    .run_en_i        (run_en),
    .invalid_o       (hw_invalid),
    .illegal_trans_o (hw_illegal),
    .short_yel_o     (hw_short),
    .long_yel_o      (hw_long),
    .yel_to_red_o    (hw_yel_to_red)
  );

  tlc_approach_checker #(.MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW)) u_farm (
    .clk             (clk),
    .rst_n           (rst_n),
    .cur_i           (farm_light),
    .prev_i          (fm_prev_q),
    .run_en_i        (run_en),
    .invalid_o       (fm_invalid),
    .illegal_trans_o (fm_illegal),
    .short_yel_o     (fm_short),
    .long_yel_o      (fm_long),
    .yel_to_red_o    (fm_yel_to_red)
  );

  always_comb begin
    det_code = FC_NONE;
    if (hw_invalid || fm_invalid)        det_code = FC_INVALID;
    else if (run_en && conflict)         det_code = FC_CONFLICT;
    else if (hw_illegal || fm_illegal)   det_code = FC_ILLEGAL;
    else if (hw_short || fm_short)       det_code = FC_SHORT_YEL;
    else if (hw_long || fm_long)         det_code = FC_LONG_YEL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARM;
      hw_prev_q    <= RED;
      fm_prev_q    <= RED;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
      flash_red_q  <= 1'b0;
      cycle_cnt_q  <= '0;
    end else begin
      hw_prev_q <= hw_cur;
      fm_prev_q <= fm_cur;
      unique case (state_q)
        ST_ARM: state_q <= ST_RUN;
        ST_RUN: begin
          if (det_code != FC_NONE) begin
            state_q      <= ST_FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= det_code;
            flash_red_q  <= 1'b1;
          end else if (hw_yel_to_red && cycle_cnt_q != 16'hFFFF) begin
            cycle_cnt_q <= cycle_cnt_q + 16'd1;
          end
        end
        ST_FAULT: begin
          // Release only when both approaches already show red.
          if (fault_clr && both_red) begin
            state_q      <= ST_ARM;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            flash_red_q  <= 1'b0;
          end
        end
        default: state_q <= ST_ARM;
      endcase
    end
  end

  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign flash_red  = flash_red_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Self-checking bench for light_conflict_monitor: directed lamp sequences,
// a behavioural model compared every cycle, and literal spot checks.
module tb_light_conflict_monitor;

  localparam int MIN_Y = 20;
  localparam int MAX_Y = 40;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  hw    = 2'b10;
  logic [1:0]  fm    = 2'b10;
  logic        clr   = 1'b0;
  logic        fault;
  logic [2:0]  fault_code;
  logic        flash_red;
  logic [15:0] cycle_cnt;

  int total = 0;
  int bad   = 0;

  light_conflict_monitor #(.MIN_YELLOW(MIN_Y), .MAX_YELLOW(MAX_Y)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .highway_light (hw),
    .farm_light    (fm),
    .fault_clr     (clr),
    .fault         (fault),
    .fault_code    (fault_code),
    .flash_red     (flash_red),
    .cycle_cnt     (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = arming, 1 = watching, 2 = faulted.
  // Yellow dwell is tracked as a plain run length of yellow samples.
  int m_mode  = 0;
  int m_fault = 0;
  int m_code  = 0;
  int m_cnt   = 0;
  int m_prev [2] = '{2, 2};
  int m_ylen [2] = '{0, 0};

  always @(posedge clk or negedge rst_n) begin : model
    int cur [2];
    int nlen [2];
    int code;
    logic any_inv, any_ill, any_short, any_long;
    if (!rst_n) begin
      m_mode = 0; m_fault = 0; m_code = 0; m_cnt = 0;
      m_prev = '{2, 2}; m_ylen = '{0, 0};
    end else begin
      cur[0] = int'(hw);
      cur[1] = int'(fm);
      if (m_mode == 0) begin
        m_prev = cur; m_ylen = '{0, 0}; m_mode = 1;
      end else if (m_mode == 1) begin
        any_inv = 0; any_ill = 0; any_short = 0; any_long = 0;
        for (int i = 0; i < 2; i++) begin
          nlen[i] = (cur[i] == 1) ? m_ylen[i] + 1 : 0;
          if (cur[i] == 3) any_inv = 1;
          // Legal lamps step forward in the green->yellow->red rotation or hold.
          if (!(cur[i] == m_prev[i] ||
                (m_prev[i] != 3 && cur[i] != 3 && cur[i] == (m_prev[i] + 1) % 3)))
            any_ill = 1;
          if (m_prev[i] == 1 && cur[i] == 2 && m_ylen[i] < MIN_Y) any_short = 1;
          if (nlen[i] == MAX_Y + 1) any_long = 1;
        end
        code = 0;
        if (any_inv)                     code = 1;
        else if (cur[0] != 2 && cur[1] != 2) code = 2;
        else if (any_ill)                code = 3;
        else if (any_short)              code = 4;
        else if (any_long)               code = 5;
        if (code != 0) begin
          m_mode = 2; m_fault = 1; m_code = code; m_ylen = '{0, 0};
        end else begin
          if (m_prev[0] == 1 && cur[0] == 2 && m_cnt < 65535) m_cnt++;
          m_ylen = nlen;
        end
        m_prev = cur;
      end else begin
        m_ylen = '{0, 0};
        if (clr && cur[0] == 2 && cur[1] == 2) begin
          m_mode = 0; m_fault = 0; m_code = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_fault", 32'(fault), 32'(m_fault));
    check("cmp_code", 32'(fault_code), 32'(m_code));
    check("cmp_flash", 32'(flash_red), 32'(m_fault));
    check("cmp_cycles", 32'(cycle_cnt), 32'(m_cnt));
  end

  task automatic drive(input logic [1:0] h, input logic [1:0] f, input logic c, input int n);
    repeat (n) begin
      hw = h; fm = f; clr = c;
      @(negedge clk);
    end
  endtask

  task automatic hw_cycle(input int yel);
    drive(2'b00, 2'b10, 1'b0, 30);
    drive(2'b01, 2'b10, 1'b0, yel);
    drive(2'b10, 2'b10, 1'b0, 1);
  endtask

  task automatic farm_cycle(input int yel);
    drive(2'b10, 2'b00, 1'b0, 5);
    drive(2'b10, 2'b01, 1'b0, yel);
    drive(2'b10, 2'b10, 1'b0, 1);
  endtask

  // Exit edge followed by the ARM edge; leaves the monitor watching.
  task automatic clear_fault();
    drive(2'b10, 2'b10, 1'b1, 1);
    drive(2'b10, 2'b10, 1'b0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fault"}, 32'(fault), 0);
    check({tag, "_code"}, 32'(fault_code), 0);
    check({tag, "_flash"}, 32'(flash_red), 0);
    check({tag, "_cycles"}, 32'(cycle_cnt), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    drive(2'b10, 2'b10, 1'b0, 1);

    for (int k = 0; k < 3; k++) begin
      hw_cycle(21);
      farm_cycle(21);
    end
    check("legal_fault", 32'(fault), 0);
    check("legal_cycles", 32'(cycle_cnt), 3);

    // Yellow exactly MIN on highway, exactly MAX on farm; clear request in RUN.
    drive(2'b10, 2'b10, 1'b1, 2);
    hw_cycle(20);
    farm_cycle(40);
    check("bound_fault", 32'(fault), 0);
    check("bound_cycles", 32'(cycle_cnt), 4);

    drive(2'b00, 2'b00, 1'b0, 1);
    check("conflict_fault", 32'(fault), 1);
    check("conflict_code", 32'(fault_code), 2);
    check("conflict_flash", 32'(flash_red), 1);
    drive(2'b11, 2'b00, 1'b0, 1);
    check("held_code", 32'(fault_code), 2);
    drive(2'b10, 2'b10, 1'b0, 1);
    check("frozen_cycles", 32'(cycle_cnt), 4);
    drive(2'b00, 2'b10, 1'b1, 1);
    check("clr_not_red", 32'(fault), 1);
    drive(2'b10, 2'b10, 1'b0, 1);
    check("clr_forgotten", 32'(fault), 1);
    drive(2'b10, 2'b10, 1'b1, 1);
    check("exit_fault", 32'(fault), 0);
    check("exit_code", 32'(fault_code), 0);
    check("exit_flash", 32'(flash_red), 0);
    drive(2'b10, 2'b10, 1'b0, 1);

    // Short yellow with fault_clr on the same edge: the fault must win.
    drive(2'b00, 2'b10, 1'b0, 3);
    drive(2'b01, 2'b10, 1'b0, 5);
    drive(2'b10, 2'b10, 1'b1, 1);
    check("short_fault", 32'(fault), 1);
    check("short_code", 32'(fault_code), 4);
    clear_fault();

    drive(2'b00, 2'b10, 1'b0, 2);
    drive(2'b01, 2'b10, 1'b0, 40);
    check("yel40_fault", 32'(fault), 0);
    drive(2'b01, 2'b10, 1'b0, 1);
    check("long_code", 32'(fault_code), 5);
    clear_fault();

    drive(2'b00, 2'b10, 1'b0, 2);
    drive(2'b10, 2'b10, 1'b0, 1);
    check("illegal_code", 32'(fault_code), 3);
    clear_fault();

    drive(2'b11, 2'b00, 1'b0, 1);
    check("priority_code", 32'(fault_code), 1);
    clear_fault();
    check("kept_cycles", 32'(cycle_cnt), 4);

    // Asynchronous reset mid-yellow, then yellow straddling release.
    drive(2'b00, 2'b10, 1'b0, 2);
    drive(2'b01, 2'b10, 1'b0, 2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_yel");
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b01, 2'b10, 1'b0, 1);
    check("arm_edge_fault", 32'(fault), 0);

    drive(2'b01, 2'b00, 1'b0, 1);
    check("pre_rst_code", 32'(fault_code), 2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_fault");
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b10, 2'b10, 1'b0, 2);
    check("post_rst_fault", 32'(fault), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/light_conflict_monitor.md
LIGHT_CONFLICT_MONITOR -- requirements
Module: light_conflict_monitor

Interface
REQ-001 Parameter MIN_YELLOW, default 20: minimum legal consecutive yellow samples per approach.
REQ-002 Parameter MAX_YELLOW, default 40: maximum legal consecutive yellow samples per approach; legal range MIN_YELLOW < MAX_YELLOW < 63.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 highway_light  input  2  highway lamp code, synchronous to clk: 00 green, 01 yellow, 10 red, 11 invalid.
REQ-006 farm_light  input  2  farm lamp code, same encoding.
REQ-007 fault_clr  input  1  request to leave FAULT, level-sampled.
REQ-008 fault  output  1  registered; high while in FAULT.
REQ-009 fault_code  output  3  registered; first latched fault cause, 0 when none.
REQ-010 flash_red  output  1  registered; lamp-override request, equal to fault.
REQ-011 cycle_cnt  output  16  registered; completed legal highway cycles, saturating at 0xFFFF.

Function
REQ-012 Monitor states: ARM, RUN, FAULT.
REQ-013 ARM: capture both lamp codes as previous values with no checks; go to RUN on the next edge.
REQ-014 RUN: every edge, compare the current inputs against the registered previous values and dwell counters; update previous values.
REQ-015 Fault codes and priority, highest first: 1 invalid code 11 on either approach; 2 both approaches non-red; 3 illegal transition; 4 short yellow; 5 long yellow.
REQ-016 Legal per-approach transitions: hold, green->yellow, yellow->red, red->green. All other transitions are code 3.
REQ-017 Per-approach yellow counter: 6-bit; set to 1 on the first yellow sample; +1 on each further yellow sample; saturates at 63; cleared on any non-yellow sample.
REQ-018 Code 4: fires on the edge that samples a yellow->red change while the counter < MIN_YELLOW.
REQ-019 Code 5: fires on the edge where the counter would become MAX_YELLOW+1.
REQ-020 Detection latency: a fault detected on the edge that samples the offending input is visible on fault/fault_code immediately after that edge, i.e. 1 cycle.
REQ-021 On any detected fault in RUN: go to FAULT and latch the highest-priority code.
REQ-022 FAULT: fault_code is held; later faults are ignored; cycle_cnt is frozen.
REQ-023 FAULT exit: requires fault_clr=1 on an edge where both inputs are 10. On that edge go to ARM and clear fault, fault_code and flash_red. Other fault_clr assertions are ignored and not remembered.
REQ-024 fault_clr in ARM or RUN: no effect. A fault and fault_clr on the same RUN edge: the fault wins.
REQ-025 cycle_cnt: +1 on each legal highway yellow->red transition with no fault on that edge.

Reset
REQ-026 While rst_n=0: state=ARM, fault=0, fault_code=0, flash_red=0, cycle_cnt=0, yellow counters=0, previous codes=10/10.
REQ-027 Reset assertion mid-operation (including in FAULT) aborts immediately with no fault record retained. The first edge after release is an ARM edge.

Structure
REQ-028 Package tlc_pkg holds:
  - lamp-code typedef (GREEN, YELLOW, RED, INVALID);
  - fault-code enum;
  - monitor-state enum;
  - MIN_YELLOW and MAX_YELLOW default constants.
REQ-029 Sub-module tlc_approach_checker, instantiated once per approach:
  - inputs: current code, previous code, run enable;
  - contains: yellow counter;
  - outputs: invalid, illegal_trans, short_yel, long_yel, yel_to_red.
REQ-030 Priority encoding, conflict check, FSM and cycle_cnt reside in light_conflict_monitor.

Verification
REQ-031 Legal sequence: highway 00 x30, 01 x21, 10; farm 10 -> 00 -> 01 x21 -> 10; repeat 3 times -> fault stays 0, cycle_cnt=3.
REQ-032 highway 00, farm 00 in RUN -> fault=1, fault_code=2 one cycle later. A later invalid 11 does not change fault_code (still 2).
REQ-033 Short yellow: highway yellow for 5 samples, then red -> fault_code=4. Long yellow: highway yellow for 41 samples -> fault_code=5 on the 41st sample edge.
REQ-034 highway 00->10 directly -> code 3. With highway 11 and farm 00 on the same edge -> code 1 (priority).
REQ-035 In FAULT: fault_clr=1 with highway 00 -> remains in FAULT. fault_clr=1 with both 10 -> fault=0, fault_code=0, then ARM, then RUN.
REQ-036 rst_n pulsed low mid-yellow and in FAULT -> all outputs 0 asynchronously. A short yellow straddling reset release is not flagged on the first (ARM) edge.
